// File: rtl/dcm_clock_governor_pkg.sv
// Shared types, widths and default limits for the DCM clock governor.
// Multiplier arithmetic runs one bit wider than storage so steps never wrap.
package dcm_clock_governor_pkg;

    localparam int MULT_W        = 8;
    localparam int INT_W         = 9;
    localparam int DEF_MAX_MULT  = 88;
    localparam int DEF_MIN_MULT  = 20;
    localparam int DEF_INIT_MULT = 60;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } gov_state_t;

    function automatic logic [MULT_W-1:0] clamp_mult(
        input logic [INT_W-1:0] x,
        input logic [INT_W-1:0] lo,
        input logic [INT_W-1:0] hi
    );
        logic [INT_W-1:0] r;
        if (x < lo) begin
            r = lo;
        end else if (x > hi) begin
            r = hi;
        end else begin
            r = x;
        end
        return r[MULT_W-1:0];
    endfunction

endpackage

// File: rtl/dcm_clock_governor_err.sv
// Error-sampling window: counts hash errors per window and clean windows,
// emitting single-cycle step_up / step_down decisions at window end.
module dcm_err_window
    import dcm_clock_governor_pkg::*;
#(
    parameter int WINDOW_CYCLES = 16777216,
    parameter int ERR_THRESHOLD = 4,
    parameter int CLEAN_WINDOWS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic hold,
    input  logic hash_err,
    output logic step_up,
    output logic step_down
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int CLN_W = $clog2(CLEAN_WINDOWS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CLN_W-1:0] CLN_LAST = CLN_W'(CLEAN_WINDOWS - 1);
    localparam logic [7:0]       ERR_TH   = 8'(ERR_THRESHOLD);

    logic [WIN_W-1:0] win_cnt_r;
    logic [7:0]       err_cnt_r;
    logic [CLN_W-1:0] clean_cnt_r;
    logic [7:0]       err_next_s;
    logic             win_end_s;

    // Error count including this cycle's pulse, and window-end decisions
    always_comb begin
        if (hash_err && (err_cnt_r != 8'hFF)) begin
            err_next_s = err_cnt_r + 8'd1;
        end else begin
            err_next_s = err_cnt_r;
        end
        win_end_s = (win_cnt_r == WIN_LAST) && !restart && !hold;
        step_down = win_end_s && (err_next_s >= ERR_TH);
        step_up   = win_end_s && (err_next_s == 8'd0) && (clean_cnt_r == CLN_LAST);
    end

    // Window, error and clean-window counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_r   <= '0;
            err_cnt_r   <= 8'd0;
            clean_cnt_r <= '0;
        end else if (restart) begin
            win_cnt_r   <= '0;
            err_cnt_r   <= 8'd0;
            clean_cnt_r <= '0;
        end else if (hold) begin
            win_cnt_r   <= '0;
            err_cnt_r   <= 8'd0;
        end else if (win_cnt_r == WIN_LAST) begin
            win_cnt_r <= '0;
            err_cnt_r <= 8'd0;
            if ((err_next_s == 8'd0) && (clean_cnt_r != CLN_LAST)) begin
                clean_cnt_r <= clean_cnt_r + CLN_W'(1);
            end else begin
                clean_cnt_r <= '0;
            end
        end else begin
            win_cnt_r <= win_cnt_r + WIN_W'(1);
            err_cnt_r <= err_next_s;
        end
    end

endmodule

// File: rtl/dcm_clock_governor.sv
// Clock governor top: target/ceiling arithmetic and the request/ack issue FSM
// that hands the chosen multiplier to the DCM programmer.
module dcm_clock_governor
    import dcm_clock_governor_pkg::*;
#(
    parameter int MAXIMUM_MULTIPLIER = DEF_MAX_MULT,
    parameter int MINIMUM_MULTIPLIER = DEF_MIN_MULT,
    parameter int INITIAL_MULTIPLIER = DEF_INIT_MULT,
    parameter int STEP               = 2,
    parameter int WINDOW_CYCLES      = 16777216,
    parameter int ERR_THRESHOLD      = 4,
    parameter int CLEAN_WINDOWS      = 4,
    parameter int HOLDOFF_CYCLES     = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_set,
    input  logic [MULT_W-1:0] host_mult,
    input  logic              hash_err,
    input  logic              thermal_alarm,
    output logic              prog_req,
    output logic [MULT_W-1:0] prog_mult,
    input  logic              prog_ack,
    output logic [MULT_W-1:0] current_mult,
    output logic [MULT_W-1:0] ceiling,
    output logic              throttled
);

    localparam logic [INT_W-1:0]  MIN_W  = INT_W'(MINIMUM_MULTIPLIER);
    localparam logic [INT_W-1:0]  MAX_W  = INT_W'(MAXIMUM_MULTIPLIER);
    localparam logic [INT_W-1:0]  STEP_W = INT_W'(STEP);
    localparam logic [MULT_W-1:0] MIN_M  = MULT_W'(MINIMUM_MULTIPLIER);
    localparam logic [MULT_W-1:0] INIT_M = MULT_W'(INITIAL_MULTIPLIER);
    localparam int                HC_W   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HC_W-1:0]   HC_LAST = HC_W'(HOLDOFF_CYCLES - 1);

    gov_state_t        state_r, state_s;
    logic              prog_req_r, prog_req_s;
    logic [MULT_W-1:0] prog_mult_r, prog_mult_s;
    logic [MULT_W-1:0] current_mult_r, current_mult_s;
    logic [HC_W-1:0]   hold_cnt_r, hold_cnt_s;
    logic [MULT_W-1:0] target_r, target_s;
    logic [MULT_W-1:0] ceiling_r, ceiling_s;
    logic              throttled_r;
    logic [MULT_W-1:0] host_clamp_s, target_dn_s, target_up_s;
    logic [INT_W-1:0]  dn_wide_s, up_wide_s;
    logic              step_up_s, step_down_s;

    dcm_err_window #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .ERR_THRESHOLD (ERR_THRESHOLD),
        .CLEAN_WINDOWS (CLEAN_WINDOWS)
    ) u_err_window (
        .clk       (clk),
        .rst       (rst),
        .restart   (thermal_alarm || host_set),
        .hold      (state_r == HOLDOFF),
        .hash_err  (hash_err),
        .step_up   (step_up_s),
        .step_down (step_down_s)
    );

    // Candidate targets: clamped host value, one step down, one step up
    always_comb begin
        host_clamp_s = clamp_mult({1'b0, host_mult}, MIN_W, MAX_W);
        if ({1'b0, target_r} >= (MIN_W + STEP_W)) begin
            dn_wide_s = {1'b0, target_r} - STEP_W;
        end else begin
            dn_wide_s = MIN_W;
        end
        up_wide_s = {1'b0, target_r} + STEP_W;
        if (up_wide_s > {1'b0, ceiling_r}) begin
            up_wide_s = {1'b0, ceiling_r};
        end else begin
            up_wide_s = up_wide_s;
        end
        target_dn_s = clamp_mult(dn_wide_s, MIN_W, MAX_W);
        target_up_s = clamp_mult(up_wide_s, MIN_W, MAX_W);
    end

    // Prioritised target/ceiling update: thermal, host, then window decisions
    always_comb begin
        target_s  = target_r;
        ceiling_s = ceiling_r;
        if (thermal_alarm) begin
            target_s = MIN_M;
        end else if (host_set) begin
            ceiling_s = host_clamp_s;
            target_s  = host_clamp_s;
        end else if (step_down_s) begin
            target_s = target_dn_s;
        end else if (step_up_s) begin
            target_s = target_up_s;
        end else begin
            target_s = target_r;
        end
    end

    // Issue FSM next-state and output logic
    always_comb begin
        state_s        = state_r;
        prog_req_s     = prog_req_r;
        prog_mult_s    = prog_mult_r;
        current_mult_s = current_mult_r;
        hold_cnt_s     = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (target_r != current_mult_r) begin
                    prog_mult_s = target_r;
                    prog_req_s  = 1'b1;
                    state_s     = ISSUE;
                end else begin
                    prog_req_s = 1'b0;
                end
            end
            ISSUE: begin
                if (prog_ack) begin
                    current_mult_s = prog_mult_r;
                    prog_req_s     = 1'b0;
                    hold_cnt_s     = HC_LAST;
                    state_s        = HOLDOFF;
                end else begin
                    prog_req_s = 1'b1;
                end
            end
            HOLDOFF: begin
                if (hold_cnt_r == '0) begin
                    state_s = IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r - HC_W'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                prog_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            prog_req_r     <= 1'b0;
            prog_mult_r    <= INIT_M;
            current_mult_r <= '0;
            hold_cnt_r     <= '0;
            target_r       <= INIT_M;
            ceiling_r      <= INIT_M;
            throttled_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            prog_req_r     <= prog_req_s;
            prog_mult_r    <= prog_mult_s;
            current_mult_r <= current_mult_s;
            hold_cnt_r     <= hold_cnt_s;
            target_r       <= target_s;
            ceiling_r      <= ceiling_s;
            throttled_r    <= thermal_alarm;
        end
    end

    assign prog_req     = prog_req_r;
    assign prog_mult    = prog_mult_r;
    assign current_mult = current_mult_r;
    assign ceiling      = ceiling_r;
    assign throttled    = throttled_r;

endmodule

// File: tb/tb_dcm_clock_governor.sv
// Scoreboard bench for dcm_clock_governor with shortened window and holdoff.
`timescale 1ns/1ps
module tb_dcm_clock_governor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_set = 1'b0;
    logic [7:0] host_mult = 8'd0;
    logic       hash_err = 1'b0;
    logic       thermal_alarm = 1'b0;
    logic       prog_req;
    logic [7:0] prog_mult;
    logic       prog_ack = 1'b0;
    logic [7:0] current_mult;
    logic [7:0] ceiling;
    logic       throttled;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int last_exp = 0;

    always #5 clk = ~clk;

    dcm_clock_governor #(
        .WINDOW_CYCLES  (64),
        .HOLDOFF_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_set      (host_set),
        .host_mult     (host_mult),
        .hash_err      (hash_err),
        .thermal_alarm (thermal_alarm),
        .prog_req      (prog_req),
        .prog_mult     (prog_mult),
        .prog_ack      (prog_ack),
        .current_mult  (current_mult),
        .ceiling       (ceiling),
        .throttled     (throttled)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic host_pulse(input int v);
        host_mult = 8'(v);
        host_set  = 1'b1;
        @(negedge clk);
        host_set  = 1'b0;
    endtask

    task automatic inj_errs(input int n);
        for (int i = 0; i < n; i++) begin
            hash_err = 1'b1;
            @(negedge clk);
            hash_err = 1'b0;
            @(negedge clk);
        end
    endtask

    // Wait for a request and compare prog_mult against the scoreboard head
    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!prog_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, int'(prog_req), 1);
        if (prog_req) begin
            last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 255;
            chk({tag, "_mult"}, int'(prog_mult), last_exp);
        end
    endtask

    task automatic do_ack(input string tag);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        chk({tag, "_cur"}, int'(current_mult), last_exp);
        chk({tag, "_reqlow"}, int'(prog_req), 0);
    endtask

    task automatic expect_no_req(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (prog_req) seen = 1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_req", int'(prog_req), 0);
        chk("rst_cur", int'(current_mult), 0);
        chk("rst_ceil", int'(ceiling), 60);
        chk("rst_pmult", int'(prog_mult), 60);
        chk("rst_thr", int'(throttled), 0);
        rst = 1'b0;

        // first request after reset
        exp_q.push_back(60);
        wait_req("boot", 10);
        do_ack("boot");
        expect_no_req("boot_quiet", 300);

        // host clamp high and low
        host_pulse(120);
        chk("clamp_ceil_hi", int'(ceiling), 88);
        exp_q.push_back(88);
        wait_req("clamp_hi", 10);
        do_ack("clamp_hi");
        tick(12);
        host_pulse(5);
        chk("clamp_ceil_lo", int'(ceiling), 20);
        exp_q.push_back(20);
        wait_req("clamp_lo", 10);
        do_ack("clamp_lo");
        tick(12);

        // error backoff from 60
        host_pulse(60);
        exp_q.push_back(60);
        wait_req("set60", 10);
        do_ack("set60");
        tick(12);
        inj_errs(4);
        exp_q.push_back(58);
        wait_req("backoff", 200);
        do_ack("backoff");
        tick(12);
        inj_errs(3);
        expect_no_req("three_errs", 150);

        // recovery toward ceiling 64
        host_pulse(64);
        exp_q.push_back(64);
        wait_req("set64", 10);
        do_ack("set64");
        for (int k = 0; k < 2; k++) begin
            tick(12);
            inj_errs(4);
            exp_q.push_back(62 - 2 * k);
            wait_req("down", 200);
            do_ack("down");
        end
        exp_q.push_back(62);
        wait_req("up62", 400);
        do_ack("up62");
        exp_q.push_back(64);
        wait_req("up64", 400);
        do_ack("up64");
        expect_no_req("capped", 400);
        chk("capped_cur", int'(current_mult), 64);

        // thermal alarm during ISSUE(62)
        host_pulse(64);
        tick(2);
        inj_errs(4);
        exp_q.push_back(62);
        exp_q.push_back(20);
        wait_req("therm62", 200);
        thermal_alarm = 1'b1;
        @(negedge clk);
        chk("therm_thr", int'(throttled), 1);
        chk("therm_pmult_hold", int'(prog_mult), 62);
        do_ack("therm62");
        wait_req("therm20", 100);
        do_ack("therm20");
        chk("therm_ceil", int'(ceiling), 64);
        thermal_alarm = 1'b0;
        exp_q.push_back(22);
        wait_req("therm_up", 450);
        do_ack("therm_up");
        chk("therm_thr_clr", int'(throttled), 0);

        // host_set coincides with a step-down window end
        tick(12);
        host_pulse(22);
        for (int i = 0; i < 63; i++) begin
            hash_err = (i >= 4 && i < 8);
            @(negedge clk);
        end
        hash_err = 1'b0;
        host_pulse(40);
        chk("contend_ceil", int'(ceiling), 40);
        exp_q.push_back(40);
        wait_req("contend", 10);
        do_ack("contend");

        // prog_ack outside ISSUE is ignored
        tick(12);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_cur", int'(current_mult), 40);
        expect_no_req("idle_ack_quiet", 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
